// File: rtl/write_ctrl_fsm.sv
// DDR5 PHY write-path sequencer: preamble/data/CRC/interamble/postamble
// control with a per-state watchdog that forces a return to IDLE.
module write_ctrl_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned BCNT_W         = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic              wrmask_en_i,
  input  logic [1:0]        burstlength_i,
  input  logic              crc_generate_i,
  input  logic              interamble_i,
  input  logic              preamble_done_i,
  input  logic              wrdata_done_i,
  input  logic              wrmask_done_i,
  input  logic              wrdata_crc_done_i,
  input  logic              data_burst_done_i,
  input  logic              interamble_done_i,
  input  logic              postamble_done_i,
  output logic [2:0]        state_o,
  output logic              data_state_o,
  output logic              preamble_state_o,
  output logic              interamble_valid_o,
  output logic              postamble_state_o,
  output logic              dqs_oe_o,
  output logic              dq_oe_o,
  output logic              crc_send_o,
  output logic [BCNT_W-1:0] burst_cnt_o,
  output logic              timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_DATA  = 3'd2,
    S_CRC   = 3'd3,
    S_BURST = 3'd4,
    S_INTER = 3'd5,
    S_POST  = 3'd6
  } state_t;

  localparam logic [7:0] WD_MAX = 8'(TIMEOUT_CYCLES - 1);

  state_t              state_q;
  state_t              state_d;
  state_t              fsm_d;
  state_t              exit_d;
  logic                exit_w;
  logic                abort_w;
  logic [7:0]          wd_q;
  logic [BCNT_W-1:0]   bcnt_q;
  logic                timeout_q;

  always_comb begin
    fsm_d  = state_q;
    exit_w = 1'b0;
    exit_d = (wr_en_i && interamble_i) ? S_INTER : S_POST;
    case (state_q)
      S_IDLE: begin
        if (wr_en_i) fsm_d = S_PRE;
      end
      S_PRE: begin
        if (preamble_done_i) fsm_d = S_DATA;
      end
      S_DATA: begin
        if (wrmask_en_i && wrmask_done_i) begin
          fsm_d  = exit_d;
          exit_w = 1'b1;
        end else if (wrdata_done_i && crc_generate_i) begin
          fsm_d = S_CRC;
        end else if (wrdata_done_i && burstlength_i == 2'b10) begin
          fsm_d = S_BURST;
        end else if (wrdata_done_i) begin
          fsm_d  = exit_d;
          exit_w = 1'b1;
        end
      end
      S_CRC: begin
        if (wrdata_crc_done_i) begin
          fsm_d  = exit_d;
          exit_w = 1'b1;
        end
      end
      S_BURST: begin
        if (data_burst_done_i) begin
          fsm_d  = exit_d;
          exit_w = 1'b1;
        end
      end
      S_INTER: begin
        if (interamble_done_i) fsm_d = S_DATA;
      end
      S_POST: begin
        if (postamble_done_i) fsm_d = wr_en_i ? S_PRE : S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
    // Abort only when the state would otherwise be held another cycle
    abort_w = (state_q != S_IDLE) && (fsm_d == state_q) && (wd_q == WD_MAX);
    state_d = abort_w ? S_IDLE : fsm_d;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      wd_q      <= '0;
      bcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= abort_w;
      bcnt_q    <= bcnt_q + BCNT_W'(exit_w);
      if (state_d != state_q || state_q == S_IDLE) wd_q <= '0;
      else wd_q <= wd_q + 8'd1;
    end
  end

  assign state_o            = state_q;
  assign data_state_o       = (state_q == S_DATA) || (state_q == S_CRC) ||
                              (state_q == S_BURST);
  assign preamble_state_o   = (state_q == S_PRE);
  assign interamble_valid_o = (state_q == S_INTER);
  assign postamble_state_o  = (state_q == S_POST);
  assign dqs_oe_o           = (state_q != S_IDLE);
  assign dq_oe_o            = data_state_o;
  assign crc_send_o         = (state_q == S_CRC);
  assign burst_cnt_o        = bcnt_q;
  assign timeout_o          = timeout_q;

endmodule

// File: doc/write_ctrl_fsm.md
Name: write_ctrl_fsm

Overview:
- Write-path sequencing controller of the DDR5 PHY write block; sits directly beside the write counter.
- Consumes the counter's done/decision flags and produces the state indications the counter consumes: data state, preamble state, interamble valid.
- Drives DQ/DQS output enables and CRC-send qualification toward the serializer.
- Includes a watchdog that forces recovery to IDLE if a done flag never arrives.

Parameters:
TIMEOUT_CYCLES, 64, cycles allowed in any single non-IDLE state before forced abort (range 2..255)
BCNT_W, 8, width of completed-burst counter

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-low
wr_en_i  in  1  write enable from MC
wrmask_en_i  in  1  current burst is a masked write
burstlength_i  in  2  00=BL16, 01=BL8, 10=BC8 on-the-fly
crc_generate_i  in  1  PHY generates and sends CRC
interamble_i  in  1  back-to-back gap needs interamble
preamble_done_i  in  1  preamble finished
wrdata_done_i  in  1  data finished
wrmask_done_i  in  1  masked data finished
wrdata_crc_done_i  in  1  data+CRC finished
data_burst_done_i  in  1  BC8 tail finished
interamble_done_i  in  1  interamble finished
postamble_done_i  in  1  postamble finished
state_o  out  3  encoded current state
data_state_o  out  1  in WRDATA, WRDATA_CRC or DATA_BURST
preamble_state_o  out  1  in PREAMBLE
interamble_valid_o  out  1  in INTERAMBLE
postamble_state_o  out  1  in POSTAMBLE
dqs_oe_o  out  1  any state except IDLE
dq_oe_o  out  1  equals data_state_o
crc_send_o  out  1  in WRDATA_CRC
burst_cnt_o  out  BCNT_W  completed data bursts, wraps modulo 2^BCNT_W
timeout_o  out  1  one-cycle pulse on watchdog abort

Behaviour:
- State encoding: IDLE=0, PREAMBLE=1, WRDATA=2, WRDATA_CRC=3, DATA_BURST=4, INTERAMBLE=5, POSTAMBLE=6. Code 7 is illegal and returns to IDLE on the next clock.
- Registered state with Moore output decode: outputs change the cycle after the causing edge. Done flags are sampled only in their owning state and ignored elsewhere.
- Reset (async assert, sync release):
  - state=IDLE.
  - All 1-bit outputs and burst_cnt_o = 0.
  - Watchdog counter = 0.
  - Reset mid-burst drops dq_oe_o and dqs_oe_o immediately.
- IDLE: wr_en_i=1 -> PREAMBLE.
- PREAMBLE: preamble_done_i -> WRDATA.
- WRDATA, in priority order:
  - wrmask_en_i and wrmask_done_i -> EXIT.
  - Else wrdata_done_i and crc_generate_i -> WRDATA_CRC.
  - Else wrdata_done_i and burstlength_i=10 -> DATA_BURST.
  - Else wrdata_done_i -> EXIT.
- WRDATA_CRC: wrdata_crc_done_i -> EXIT.
- DATA_BURST: data_burst_done_i -> EXIT.
- EXIT (evaluated in the exiting cycle):
  - wr_en_i and interamble_i -> INTERAMBLE.
  - Otherwise -> POSTAMBLE.
  - burst_cnt_o increments by 1 on every EXIT.
- INTERAMBLE: interamble_done_i -> WRDATA (no new preamble).
- POSTAMBLE: postamble_done_i -> PREAMBLE if wr_en_i=1, else IDLE.
- Simultaneous flags: only the flags relevant to the current state matter; priority is as listed above.
- Watchdog:
  - Counter clears on every state change and whenever in IDLE; increments each cycle otherwise.
  - When it reaches TIMEOUT_CYCLES-1 with no transition: next state=IDLE, timeout_o=1 for exactly one cycle, burst_cnt_o unchanged.
- burstlength_i=11 is treated as BL16.

Test Plan:
- BL16, no CRC, no mask:
  - Stimulus: wr_en_i 1 for 1 cycle; preamble_done_i after 5 cycles; wrdata_done_i after 8; postamble_done_i after 2.
  - Response: state sequence 0,1,2,6,0; dq_oe_o high exactly 8 cycles; burst_cnt_o=1.
- CRC path:
  - Stimulus: crc_generate_i=1, wrdata_done_i, then wrdata_crc_done_i 2 cycles later.
  - Response: crc_send_o high for 2 cycles; data_state_o continuous through WRDATA->WRDATA_CRC; then POSTAMBLE.
- Back-to-back:
  - Stimulus: wr_en_i=1 and interamble_i=1 at wrdata_done_i; interamble_done_i after 3 cycles.
  - Response: INTERAMBLE for 3 cycles, interamble_valid_o=1, return to WRDATA; preamble_state_o never reasserts; burst_cnt_o=2 after the second burst.
- BC8 and mask:
  - Stimulus A: burstlength_i=10 -> DATA_BURST, exits on data_burst_done_i.
  - Stimulus B: wrmask_en_i=1 with wrmask_done_i -> exits directly, wrdata_done_i ignored.
- Watchdog:
  - Stimulus: TIMEOUT_CYCLES=8, hold in PREAMBLE with no preamble_done_i.
  - Response: after 8 cycles, timeout_o pulses once; state=0; dqs_oe_o=0.
- Async reset mid-WRDATA:
  - Stimulus: assert rst_i low mid-WRDATA.
  - Response: all outputs 0 without a clock edge; on release, state=IDLE and burst_cnt_o=0.
